// File: rtl/wb_burst_master.sv
// wb_burst_master: pipelined Wishbone initiator issuing one burst of len sequential word
// transfers per start command. Read data streams out on rdat_o/rvld_o; write data is pulled
// from a first-word-fall-through source via wreq_o. bst_o flags that more requests follow.
// Optional macro WB_MASTER_STALL_EN adds stall_i: a request only counts when stb_o && !stall_i.
// DELAY is kept for drop-in compatibility with older simulation models; outputs here are
// registered without any intra-assignment delay.
module wb_burst_master #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SBITS = 10,
    parameter int unsigned LBITS = 10,
    parameter int unsigned DELAY = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             read_i,
    input  logic [SBITS-1:0] addr_i,
    input  logic [LBITS-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    input  logic [WIDTH-1:0] wdat_i,
    output logic             wreq_o,
    output logic [WIDTH-1:0] rdat_o,
    output logic             rvld_o,
    output logic             cyc_o,
    output logic             stb_o,
    output logic             we_o,
    output logic             bst_o,
    output logic [SBITS-1:0] adr_o,
    output logic [WIDTH-1:0] dat_o,
    input  logic             ack_i,
`ifdef WB_MASTER_STALL_EN
    input  logic             stall_i,
`endif
    input  logic [WIDTH-1:0] dat_i
);

    localparam logic [LBITS-1:0] LenOne = LBITS'(1);
    localparam logic [SBITS-1:0] AdrOne = SBITS'(1);

    // Compatibility-only parameter; nothing is generated from it.
    if (DELAY > 0) begin : g_delay_compat
    end

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

    state_e           state_q, state_d;
    logic [LBITS-1:0] len_q, len_d;
    logic [LBITS-1:0] iss_q, iss_d;
    logic [LBITS-1:0] ack_q, ack_d;
    logic [LBITS-1:0] ack_cnt;
    logic [SBITS-1:0] adr_q, adr_d;
    logic             cyc_q, cyc_d;
    logic             stb_q, stb_d;
    logic             we_q, we_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] rdat_q;
    logic             rvld_q;

    logic             stalled;
    logic             issue;
    logic             last_issue;
    logic             ack_ok;
    logic             all_acked;

`ifdef WB_MASTER_STALL_EN
    assign stalled = stall_i;
`else
    assign stalled = 1'b0;
`endif

    // A request is issued in every unstalled strobe cycle.
    assign issue      = stb_q && !stalled;
    assign last_issue = issue && ((iss_q + LenOne) == len_q);
    // Acks outside a cycle, or beyond the burst length, are not ours to count.
    assign ack_ok     = cyc_q && ack_i && (ack_q != len_q);
    assign ack_cnt    = ack_q + LBITS'(ack_ok);
    assign all_acked  = (ack_cnt == len_q);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_i && (len_i != '0)) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                // A zero-latency responder can complete the burst on the last issue cycle.
                if (last_issue) begin
                    state_d = all_acked ? StIdle : StDrain;
                end
            end
            StDrain: begin
                if (all_acked) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic: next values of the registered bus controls and counters.
    always_comb begin
        len_d  = len_q;
        iss_d  = iss_q;
        ack_d  = ack_cnt;
        adr_d  = adr_q;
        cyc_d  = cyc_q;
        stb_d  = stb_q;
        we_d   = we_q;
        busy_d = busy_q;
        done_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                iss_d = '0;
                ack_d = '0;
                if (start_i) begin
                    if (len_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        len_d  = len_i;
                        adr_d  = addr_i;
                        we_d   = !read_i;
                        cyc_d  = 1'b1;
                        stb_d  = 1'b1;
                        busy_d = 1'b1;
                    end
                end
            end
            StIssue, StDrain: begin
                if (issue) begin
                    adr_d = adr_q + AdrOne;
                    iss_d = iss_q + LenOne;
                end
                if (last_issue) begin
                    stb_d = 1'b0;
                end
                if (state_d == StIdle) begin
                    cyc_d  = 1'b0;
                    stb_d  = 1'b0;
                    we_d   = 1'b0;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            len_q  <= '0;
            iss_q  <= '0;
            ack_q  <= '0;
            adr_q  <= '0;
            cyc_q  <= 1'b0;
            stb_q  <= 1'b0;
            we_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            rdat_q <= '0;
            rvld_q <= 1'b0;
        end else begin
            len_q  <= len_d;
            iss_q  <= iss_d;
            ack_q  <= ack_d;
            adr_q  <= adr_d;
            cyc_q  <= cyc_d;
            stb_q  <= stb_d;
            we_q   <= we_d;
            busy_q <= busy_d;
            done_q <= done_d;
            rvld_q <= ack_ok && !we_q;
            if (ack_ok && !we_q) begin
                rdat_q <= dat_i;
            end
        end
    end

    assign cyc_o  = cyc_q;
    assign stb_o  = stb_q;
    assign we_o   = we_q;
    assign adr_o  = adr_q;
    assign busy_o = busy_q;
    assign done_o = done_q;
    assign rdat_o = rdat_q;
    assign rvld_o = rvld_q;
    // More requests follow this one while more than one word remains to issue.
    assign bst_o  = stb_q && ((len_q - iss_q) > LenOne);
    assign wreq_o = issue && we_q;
    assign dat_o  = (stb_q && we_q) ? wdat_i : '0;

endmodule

// File: tb/tb_wb_burst_master.sv
// Self-checking bench for wb_burst_master: SRAM responder with one-cycle ack, FWFT write
// source, reference model built from the burst rules, and a scoreboard monitor.
`timescale 1ns/1ps
module tb_wb_burst_master;

    typedef struct packed {
        logic [9:0]  adr;
        logic        bst;
        logic        we;
        logic [31:0] dat;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        preload = 1'b1;
    logic        start = 1'b0;
    logic        read = 1'b0;
    logic [9:0]  addr = '0;
    logic [9:0]  len = '0;
    logic        stall = 1'b0;
    logic        ack = 1'b0;
    logic [31:0] bus_rd = '0;
    logic        busy, done, wreq, rvld, cyc, stb, we, bst;
    logic [31:0] wdat, rdat, wb_dat_o;
    logic [9:0]  adr;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic [31:0] src     [0:255];
    logic [7:0]  src_rd = '0;
    logic [7:0]  src_wr = '0;

    beat_t       beat_q[$];
    logic [31:0] rd_q[$];
    int          done_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cycle = 0;
    int          wreq_seen = 0;
    int          wreq_exp = 0;

    wb_burst_master #(
        .WIDTH(32),
        .SBITS(10),
        .LBITS(10),
        .DELAY(3)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .start_i(start),
        .read_i (read),
        .addr_i (addr),
        .len_i  (len),
        .busy_o (busy),
        .done_o (done),
        .wdat_i (wdat),
        .wreq_o (wreq),
        .rdat_o (rdat),
        .rvld_o (rvld),
        .cyc_o  (cyc),
        .stb_o  (stb),
        .we_o   (we),
        .bst_o  (bst),
        .adr_o  (adr),
        .dat_o  (wb_dat_o),
        .ack_i  (ack),
`ifdef WB_MASTER_STALL_EN
        .stall_i(stall),
`endif
        .dat_i  (bus_rd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [31:0] init_word(input int i);
        if (i >= 16 && i < 20) return 32'hA0 + 32'(i - 16);
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // SRAM responder: registered ack for every accepted request; not tied to the master reset.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
            ack <= 1'b0;
        end else begin
            ack <= cyc && stb && !stall;
            if (cyc && stb && !stall) begin
                if (we) mem[adr] <= wb_dat_o;
                else    bus_rd   <= mem[adr];
            end
        end
    end

    // FWFT write source.
    assign wdat = src[src_rd];
    always @(posedge clk) if (wreq) src_rd <= src_rd + 8'd1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin
        beat_t b;
        if (!rst && !preload) begin
            if (wreq) wreq_seen++;
            if (stb) begin
                if (beat_q.size() == 0) begin
                    check("stb_unexpected", 64'(stb), 64'd0);
                end else if (stall) begin
                    check("stall_adr_hold", 64'(adr), 64'(beat_q[0].adr));
                    if (beat_q[0].we) check("stall_dat_hold", 64'(wb_dat_o), 64'(beat_q[0].dat));
                    check("stall_no_wreq", 64'(wreq), 64'd0);
                end else begin
                    b = beat_q.pop_front();
                    check("adr", 64'(adr), 64'(b.adr));
                    check("bst", 64'(bst), 64'(b.bst));
                    check("we", 64'(we), 64'(b.we));
                    check("cyc_with_stb", 64'(cyc), 64'd1);
                    check("wreq", 64'(wreq), 64'(b.we));
                    if (b.we) check("wdat", 64'(wb_dat_o), 64'(b.dat));
                end
            end
            if (rvld) begin
                if (rd_q.size() == 0) check("rvld_unexpected", 64'(rvld), 64'd0);
                else check("rdat", 64'(rdat), 64'(rd_q.pop_front()));
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    check("done_unexpected", 64'(done), 64'd0);
                end else begin
                    check("done_cycle", 64'(cycle), 64'(done_q.pop_front()));
                    check("cyc_low_at_done", 64'(cyc), 64'd0);
                    check("busy_low_at_done", 64'(busy), 64'd0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_src(input logic [31:0] w);
        src[src_wr] = w;
        src_wr = src_wr + 8'd1;
    endtask

    // Reference model: expected beats, read data and done time for one command.
    task automatic issue_cmd(input logic rd, input logic [9:0] a, input logic [9:0] n,
                             input int extra);
        beat_t      b;
        logic [7:0] sb;
        sb = src_wr - 8'(n);
        for (int i = 0; i < int'(n); i++) begin
            b.adr = a + 10'(i);
            b.bst = (i < int'(n) - 1);
            b.we  = !rd;
            b.dat = rd ? 32'h0 : src[sb + 8'(i)];
            beat_q.push_back(b);
            if (rd) rd_q.push_back(ref_mem[b.adr]);
            else begin
                ref_mem[b.adr] = b.dat;
                wreq_exp++;
            end
        end
        done_q.push_back((n == 0) ? cycle + 1 : cycle + int'(n) + 2 + extra);
        start = 1'b1;
        read  = rd;
        addr  = a;
        len   = n;
        tick();
        start = 1'b0;
        read  = 1'($urandom);
        addr  = 10'($urandom);
        len   = 10'($urandom);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || beat_q.size() != 0 || rd_q.size() != 0 || done_q.size() != 0) &&
               n < 300) begin
            tick();
            n++;
        end
        check({"complete_", name}, 64'(n < 300), 64'd1);
        tick();
    endtask

    task automatic check_mem(input logic [9:0] a, input logic [9:0] n);
        for (int i = 0; i < int'(n); i++) begin
            check("mem_word", 64'(mem[a + 10'(i)]), 64'(ref_mem[a + 10'(i)]));
        end
        check("wreq_count", 64'(wreq_seen), 64'(wreq_exp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not terminate (cycle %0d)", cycle);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       rd;
        logic [9:0] a;
        logic [9:0] n;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        repeat (3) tick();
        preload = 1'b0;
        rst     = 1'b0;

        // Reset state.
        check("rst_cyc", 64'(cyc), 64'd0);
        check("rst_stb", 64'(stb), 64'd0);
        check("rst_we", 64'(we), 64'd0);
        check("rst_bst", 64'(bst), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rvld", 64'(rvld), 64'd0);
        check("rst_adr", 64'(adr), 64'd0);
        check("rst_rdat", 64'(rdat), 64'd0);
        tick();

        // Read burst 0x010 x4: data 0xA0..0xA3, done 6 cycles after start.
        issue_cmd(1'b1, 10'h010, 10'd4, 0);
        wait_idle("read4");

        // Write burst wrapping past the top of the address space.
        load_src(32'h11);
        load_src(32'h22);
        load_src(32'h33);
        issue_cmd(1'b0, 10'h3FE, 10'd3, 0);
        wait_idle("write_wrap");
        check("wrap_3fe", 64'(mem[10'h3FE]), 64'h11);
        check("wrap_3ff", 64'(mem[10'h3FF]), 64'h22);
        check("wrap_000", 64'(mem[10'h000]), 64'h33);
        check("wrap_wreq", 64'(wreq_seen), 64'd3);

        // Single-word read, then zero-length command.
        issue_cmd(1'b1, 10'h123, 10'd1, 0);
        wait_idle("len1");
        issue_cmd(1'b1, 10'h200, 10'd0, 0);
        check("len0_no_cyc", 64'(cyc), 64'd0);
        check("len0_done", 64'(done), 64'd1);
        wait_idle("len0");

        // Start while busy must be ignored.
        issue_cmd(1'b1, 10'h100, 10'd6, 0);
        tick();
        start = 1'b1;
        read  = 1'b0;
        addr  = 10'h2AA;
        len   = 10'd2;
        tick();
        start = 1'b0;
        wait_idle("start_while_busy");

        // Reset two cycles into a len 8 read.
        issue_cmd(1'b1, 10'h050, 10'd8, 0);
        tick();
        rst = 1'b1;
        tick();
        check("midrst_cyc", 64'(cyc), 64'd0);
        check("midrst_stb", 64'(stb), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_rvld", 64'(rvld), 64'd0);
        beat_q.delete();
        rd_q.delete();
        done_q.delete();
        rst = 1'b0;
        repeat (12) tick();
        issue_cmd(1'b1, 10'h050, 10'd8, 0);
        wait_idle("after_reset");

`ifdef WB_MASTER_STALL_EN
        // Two stall cycles on the second request of a len 4 write.
        for (int i = 0; i < 4; i++) load_src(32'hC0DE_0000 + 32'(i));
        issue_cmd(1'b0, 10'h080, 10'd4, 2);
        tick();
        stall = 1'b1;
        tick();
        tick();
        stall = 1'b0;
        wait_idle("stall");
        check_mem(10'h080, 10'd4);
`endif

        // Randomized commands.
        for (int k = 0; k < 30; k++) begin
            rd = 1'($urandom_range(0, 1));
            a  = 10'($urandom_range(0, 1023));
            n  = 10'($urandom_range(0, 12));
            if (!rd) for (int i = 0; i < int'(n); i++) load_src($urandom);
            issue_cmd(rd, a, n, 0);
            wait_idle("random");
            if (!rd) check_mem(a, n);
        end

        check("final_wreq_count", 64'(wreq_seen), 64'(wreq_exp));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
